fetch_unit: RTL

- Instruction fetch stage directly upstream of the decoder/control unit in the team's single-issue RV32I core.
- Owns the program counter and issues word reads to instruction memory over a req/ack handshake.
- Presents one instruction at a time, with its PC, to decode/execute.
- Computes the next PC from the control-unit outputs (Branch, Jal, Jalr, Imm) and the ALU result when the core retires the instruction.

---
 rtl/core_pkg.sv | 19 +
 rtl/next_pc_gen.sv | 19 +
 rtl/fetch_unit.sv | 83 ++++++++
 3 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the RV32I core front end
package core_pkg;

   typedef enum logic [1:0] {IDLE, FETCH, HOLD, FAULT} fetch_state_t;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

endpackage

// File: rtl/next_pc_gen.sv
// next_pc_gen: next-PC selection (Jalr > Jal/Branch > sequential) and misalignment check
module next_pc_gen (
   input  logic [31:0] pc,
   input  logic        branch,
   input  logic        jal,
   input  logic        jalr,
   input  logic [31:0] imm,
   input  logic [31:0] alu_result,
   output logic [31:0] next_pc,
   output logic        misaligned
);

   // jalr clears bit 0, so any remaining low-bit set means a non-word target
   always_comb begin
      next_pc    = jalr ? {alu_result[31:1], 1'b0} : (jal | branch) ? pc + imm : pc + 32'd4;
      misaligned = next_pc[1:0] != 2'b00;
   end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, fetches one word at a time and holds it until retired
module fetch_unit
   import core_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        nrst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instruction,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        instr_valid,
   input  logic        instr_done,
   input  logic        Branch,
   input  logic        Jal,
   input  logic        Jalr,
   input  logic [31:0] Imm,
   input  logic [31:0] ALU_result,
   output logic        fetch_fault
);

   fetch_state_t state;
   logic [31:0]  instr_q;
   logic [31:0]  next_pc;
   logic         misaligned;

   next_pc_gen u_next_pc_gen (
      .pc         (pc),
      .branch     (Branch),
      .jal        (Jal),
      .jalr       (Jalr),
      .imm        (Imm),
      .alu_result (ALU_result),
      .next_pc    (next_pc),
      .misaligned (misaligned)
   );

   // fetch sequencer; request/valid/fault are registered alongside the state
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         instr_q     <= NOP_INSTR;
         imem_req    <= 1'b0;
         instr_valid <= 1'b0;
         fetch_fault <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state    <= FETCH;
               imem_req <= 1'b1;
            end
            FETCH: if (imem_ack) begin
               instr_q     <= imem_rdata;
               imem_req    <= 1'b0;
               instr_valid <= 1'b1;
               state       <= HOLD;
            end
            HOLD: if (instr_done) begin
               pc          <= next_pc;
               instr_valid <= 1'b0;
               fetch_fault <= misaligned;
               imem_req    <= !misaligned;
               state       <= misaligned ? FAULT : FETCH;
            end
            FAULT: state <= FAULT;
         endcase
      end
   end

   // outputs derived from the held PC and instruction register
   always_comb begin
      imem_addr   = pc;
      pc_plus4    = pc + 32'd4;
      instruction = instr_valid ? instr_q : NOP_INSTR;
   end

endmodule
